branch_resolve_unit: RTL

- Resolves the branch predictions made at fetch against the actual outcome computed in decode.
- Keeps in-flight predictions in a small FIFO, detects mispredicts, and drives the pipeline flush/redirect.
- Returns a training update to the global branch predictor, and keeps prediction statistics.
- Sits between the fetch-stage predictor outputs (bta/bpredsel/found) and the decode-stage branch logic (pcsrcd/pcbranchd).

---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds fetch-time predictions in a small FIFO, checks them
// against decode outcomes, and drives flush/redirect, predictor training and statistics.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             brf_valid,
  input  logic             stallf,
  input  logic [31:0]      pcf,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             pred_found,
  input  logic             brd_valid,
  input  logic             stalld,
  input  logic             pcsrcd,
  input  logic [31:0]      pcbranchd,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             upd_alloc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [31:0] pcMem     [DEPTH];
  logic [31:0] targetMem [DEPTH];
  logic        takenMem  [DEPTH];
  logic        foundMem  [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             flush_q, flush_d, redirValid_q, redirValid_d;
  logic [31:0]      redirPc_q, redirPc_d;
  logic             updValid_q, updValid_d, updTaken_q, updTaken_d, updAlloc_q, updAlloc_d;
  logic [31:0]      updPc_q, updPc_d, updTarget_q, updTarget_d;
  logic [CNT_W-1:0] branchCnt_q, branchCnt_d, mispredCnt_q, mispredCnt_d;
  logic             err_q, err_d;

  logic        isNormal, fifoEmpty, fifoFull, popReq, pushReq, doWrite, doRead;
  logic        mispredictNow, headTaken, headFound;
  logic [31:0] headPc, headTarget;

  assign isNormal  = (state_q == ST_NORMAL);
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == FULL_CNT);
  assign popReq    = brd_valid & ~stalld & isNormal;

  // An empty FIFO resolves against an all-zero entry; a same-cycle push is not visible.
  assign headPc     = fifoEmpty ? 32'd0 : pcMem[rdPtr_q];
  assign headTarget = fifoEmpty ? 32'd0 : targetMem[rdPtr_q];
  assign headTaken  = fifoEmpty ? 1'b0  : takenMem[rdPtr_q];
  assign headFound  = fifoEmpty ? 1'b0  : foundMem[rdPtr_q];

  assign mispredictNow = popReq & ((headTaken != pcsrcd) |
                                   (headTaken & pcsrcd & (headTarget != pcbranchd)));
  assign pushReq = brf_valid & ~stallf & ~mispredictNow & isNormal;
  assign doWrite = pushReq & (~fifoFull | popReq);
  assign doRead  = popReq & ~fifoEmpty;

  always_comb begin
    state_d      = mispredictNow ? ST_RECOVER : ST_NORMAL;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    flush_d      = 1'b0;
    redirValid_d = 1'b0;
    redirPc_d    = redirPc_q;
    updValid_d   = 1'b0;
    updPc_d      = updPc_q;
    updTaken_d   = updTaken_q;
    updTarget_d  = updTarget_q;
    updAlloc_d   = updAlloc_q;
    branchCnt_d  = branchCnt_q;
    mispredCnt_d = mispredCnt_q;
    err_d        = err_q | (pushReq & fifoFull & ~popReq) | (popReq & fifoEmpty);

    if (popReq) begin
      updValid_d  = 1'b1;
      updPc_d     = headPc;
      updTaken_d  = pcsrcd;
      updTarget_d = pcbranchd;
      updAlloc_d  = ~headFound;
      if (branchCnt_q != '1) branchCnt_d = branchCnt_q + CNT_W'(1);
    end

    // Everything younger than a mispredicted branch is wrong-path, so the FIFO empties.
    if (mispredictNow) begin
      flush_d      = 1'b1;
      redirValid_d = 1'b1;
      redirPc_d    = pcsrcd ? pcbranchd : headPc + 32'd4;
      if (mispredCnt_q != '1) mispredCnt_d = mispredCnt_q + CNT_W'(1);
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doWrite) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doRead)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doWrite, doRead})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      pcMem[wrPtr_q]     <= pcf;
      targetMem[wrPtr_q] <= pred_target;
      takenMem[wrPtr_q]  <= pred_taken;
      foundMem[wrPtr_q]  <= pred_found;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_NORMAL;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
      flush_q      <= 1'b0;
      redirValid_q <= 1'b0;
      redirPc_q    <= '0;
      updValid_q   <= 1'b0;
      updPc_q      <= '0;
      updTaken_q   <= 1'b0;
      updTarget_q  <= '0;
      updAlloc_q   <= 1'b0;
      branchCnt_q  <= '0;
      mispredCnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      flush_q      <= flush_d;
      redirValid_q <= redirValid_d;
      redirPc_q    <= redirPc_d;
      updValid_q   <= updValid_d;
      updPc_q      <= updPc_d;
      updTaken_q   <= updTaken_d;
      updTarget_q  <= updTarget_d;
      updAlloc_q   <= updAlloc_d;
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
      err_q        <= err_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirValid_q;
  assign redirect_pc    = redirPc_q;
  assign upd_valid      = updValid_q;
  assign upd_pc         = updPc_q;
  assign upd_taken      = updTaken_q;
  assign upd_target     = updTarget_q;
  assign upd_alloc      = updAlloc_q;
  assign branch_cnt     = branchCnt_q;
  assign mispred_cnt    = mispredCnt_q;
  assign err            = err_q;

endmodule
